// File: rtl/wave_gen_if.sv
// Oscillator control and sample bus between a channel sequencer and wave_gen.
interface wave_gen_if #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 9,
  parameter int OUT_W   = 16
);
  logic                      sample_tick;
  logic                      cfg_load;
  logic [PHASE_W-1:0]        freq_word;
  logic [1:0]                wave_sel;
  logic [ADDR_W-1:0]         duty;
  logic                      phase_sync;
  logic                      cfg_pending;
  logic signed [OUT_W-1:0]   sample_out;
  logic                      sample_valid;

  modport master (
    output sample_tick, cfg_load, freq_word, wave_sel, duty, phase_sync,
    input  cfg_pending, sample_out, sample_valid
  );

  modport slave (
    input  sample_tick, cfg_load, freq_word, wave_sel, duty, phase_sync,
    output cfg_pending, sample_out, sample_valid
  );
endinterface

// File: rtl/wave_gen.sv
// Per-channel oscillator: phase accumulator addressing triangle, saw,
// square or LFSR noise, with sample-boundary config updates and a
// two-stage registered output.
module wave_gen #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 9,
  parameter int OUT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  wave_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    WAVE_TRI    = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_t;

  localparam int TRI_SHIFT = OUT_W - ADDR_W + 1;
  localparam logic signed [ADDR_W+1:0] TWO_Q = {3'b001, {(ADDR_W-1){1'b0}}};
  localparam logic signed [ADDR_W+1:0] N_PTS = {2'b01, {ADDR_W{1'b0}}};
  localparam logic signed [OUT_W+1:0]  MAX_W = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0]  MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [ADDR_W-1:0]        HALF_N = {1'b1, {(ADDR_W-1){1'b0}}};

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] act_freq, pend_freq;
  wave_t              act_sel, pend_sel, sel_r;
  logic [ADDR_W-1:0]  act_duty, pend_duty, duty_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [15:0]        lfsr;
  logic               v1;

  logic signed [ADDR_W+1:0] a_s, tri_m;
  logic signed [OUT_W+1:0]  tri_w;
  logic signed [OUT_W-1:0]  tri_val, saw_val, sq_val, noise_val, wave_val;

  // Pending config is captured on load and promoted to active on a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_freq       <= '0;
      pend_sel        <= WAVE_TRI;
      pend_duty       <= HALF_N;
      act_freq        <= '0;
      act_sel         <= WAVE_TRI;
      act_duty        <= HALF_N;
      bus.cfg_pending <= 1'b0;
    end else if (bus.cfg_load) begin
      pend_freq       <= bus.freq_word;
      pend_sel        <= wave_t'(bus.wave_sel);
      pend_duty       <= bus.duty;
      bus.cfg_pending <= 1'b1;
    end else if (bus.sample_tick && bus.cfg_pending) begin
      act_freq        <= pend_freq;
      act_sel         <= pend_sel;
      act_duty        <= pend_duty;
      bus.cfg_pending <= 1'b0;
    end
  end

  // Stage 1: latch the waveform address and advance phase and noise on a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      addr_r <= '0;
      sel_r  <= WAVE_TRI;
      duty_r <= HALF_N;
      lfsr   <= 16'hACE1;
      v1     <= 1'b0;
    end else if (bus.sample_tick) begin
      addr_r <= bus.phase_sync ? '0 : phase[PHASE_W-1 -: ADDR_W];
      phase  <= (bus.phase_sync ? '0 : phase) + act_freq;
      sel_r  <= act_sel;
      duty_r <= act_duty;
      lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      v1     <= 1'b1;
    end else begin
      v1 <= 1'b0;
      if (bus.phase_sync) phase <= '0;
    end
  end

  // Noise takes the LFSR state left-aligned to the sample width
  if (OUT_W > 16) begin : g_noise_wide
    assign noise_val = {lfsr, {(OUT_W-16){1'b0}}};
  end else begin : g_noise_narrow
    assign noise_val = lfsr[15 -: OUT_W];
  end

  // Waveform shaping of the stage-1 address; triangle is built per quadrant
  always_comb begin
    a_s = signed'({2'b00, addr_r});
    case (addr_r[ADDR_W-1 -: 2])
      2'd0:    tri_m = a_s;
      2'd1,
      2'd2:    tri_m = TWO_Q - a_s;
      default: tri_m = a_s - N_PTS;
    endcase
    tri_w = {{(OUT_W-ADDR_W){tri_m[ADDR_W+1]}}, tri_m};
    tri_w = tri_w <<< TRI_SHIFT;
    if (tri_w > MAX_W)       tri_val = MAX_O;
    else if (tri_w < -MAX_W) tri_val = -MAX_O;
    else                     tri_val = tri_w[OUT_W-1:0];
    saw_val = {~addr_r[ADDR_W-1], addr_r[ADDR_W-2:0], {(OUT_W-ADDR_W){1'b0}}};
    sq_val  = (addr_r < duty_r) ? MAX_O : -MAX_O;
    case (sel_r)
      WAVE_TRI:    wave_val = tri_val;
      WAVE_SAW:    wave_val = saw_val;
      WAVE_SQUARE: wave_val = sq_val;
      default:     wave_val = noise_val;
    endcase
  end

  // Stage 2: register the shaped sample and its one-cycle valid strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= v1;
      if (v1) bus.sample_out <= wave_val;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: stimulus pushes model predictions, an
// independent monitor pops and compares whenever a sample is presented.
module tb_wave_gen;

  localparam int PHASE_W = 24;
  localparam int ADDR_W  = 9;
  localparam int OUT_W   = 16;
  localparam int N       = 1 << ADDR_W;
  localparam int Q       = N / 4;
  localparam int MAXV    = (1 << (OUT_W-1)) - 1;
  localparam int S       = (1 << (OUT_W-1)) / Q;

  typedef struct {
    int value;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_last = 0;
  exp_t exp_q[$];

  logic [PHASE_W-1:0] m_phase;
  logic [PHASE_W-1:0] m_act_freq, m_pend_freq;
  int                 m_act_sel, m_pend_sel;
  int                 m_act_duty, m_pend_duty;
  int                 m_pending;
  logic [15:0]        m_lfsr;

  wave_gen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  wave_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] lf);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= lf[16 - taps[i]];
    return {fb, lf[15:1]};
  endfunction

  function automatic int ref_wave(input int a, input int sel, input int d, input logic [15:0] lf);
    int v;
    case (sel)
      0: begin
        if (a < Q)          v = a * S;
        else if (a < 2*Q)   v = (2*Q - a) * S;
        else if (a < 3*Q)   v = -(a - 2*Q) * S;
        else                v = -(N - a) * S;
        if (v > MAXV)  v = MAXV;
        if (v < -MAXV) v = -MAXV;
      end
      1: v = (a - N/2) * (1 << (OUT_W - ADDR_W));
      2: v = (a < d) ? MAXV : -MAXV;
      default: v = int'($signed(lf));
    endcase
    return v;
  endfunction

  // Drive one cycle of inputs, predict its effect, then check cfg_pending
  task automatic applyStimulus(input logic tick, input logic load,
                               input logic [PHASE_W-1:0] freq, input int sel,
                               input int duty, input logic sync);
    int   a;
    exp_t e;
    @(negedge clk);
    bus.sample_tick = tick;
    bus.cfg_load    = load;
    bus.freq_word   = freq;
    bus.wave_sel    = 2'(sel);
    bus.duty        = ADDR_W'(duty);
    bus.phase_sync  = sync;
    if (tick) begin
      a = sync ? 0 : int'(m_phase[PHASE_W-1 -: ADDR_W]);
      m_phase = (sync ? '0 : m_phase) + m_act_freq;
      m_lfsr  = lfsr_next(m_lfsr);
      e.value = ref_wave(a, m_act_sel, m_act_duty, m_lfsr);
      e.due   = cyc + 2;
      exp_q.push_back(e);
    end else if (sync) begin
      m_phase = '0;
    end
    if (load) begin
      m_pend_freq = freq;
      m_pend_sel  = sel;
      m_pend_duty = duty;
      m_pending   = 1;
    end else if (tick && m_pending == 1) begin
      m_act_freq = m_pend_freq;
      m_act_sel  = m_pend_sel;
      m_act_duty = m_pend_duty;
      m_pending  = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("cfg_pending", int'(bus.cfg_pending), m_pending);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 0, 0, 1'b0);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, 0, 0, 1'b0);
  endtask

  task automatic load_cfg(input logic [PHASE_W-1:0] freq, input int sel, input int duty);
    applyStimulus(1'b0, 1'b1, freq, sel, duty, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; the model forgets everything in flight
  task automatic reset_dut();
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.phase_sync  = 1'b0;
    #2;
    reset       = 1'b1;
    m_phase     = '0;
    m_act_freq  = '0;
    m_pend_freq = '0;
    m_act_sel   = 0;
    m_pend_sel  = 0;
    m_act_duty  = N/2;
    m_pend_duty = N/2;
    m_pending   = 0;
    m_lfsr      = 16'hACE1;
    exp_q.delete();
    exp_last    = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_valid", int'(bus.sample_valid), 0);
    checkOutput("reset_out", int'($signed(bus.sample_out)), 0);
    checkOutput("reset_pending", int'(bus.cfg_pending), 0);
  endtask

  // Monitor: pop on every valid, otherwise the output must hold
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_last = 0;
    end else if (bus.sample_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("latency", cyc, e.due);
        checkOutput("sample", int'($signed(bus.sample_out)), e.value);
        exp_last = e.value;
      end
    end else begin
      checkOutput("hold", int'($signed(bus.sample_out)), exp_last);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checkOutput("missing_valid", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.sample_tick = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.freq_word   = '0;
    bus.wave_sel    = 2'd0;
    bus.duty        = '0;
    bus.phase_sync  = 1'b0;

    reset_dut();
    tick_n(3);
    idle(3);

    applyStimulus(1'b1, 1'b0, '0, 0, 0, 1'b0);
    reset_dut();
    idle(3);

    load_cfg(24'd32768, 0, 0);
    tick_n(N + 8);
    idle(3);

    load_cfg(24'd32768, 1, 0);
    tick_n(N + 4);

    load_cfg(24'd32768, 2, 100);
    tick_n(N + 4);
    load_cfg(24'd32768, 2, 0);
    tick_n(20);

    applyStimulus(1'b0, 1'b1, 24'd32768, 1, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 24'd65536, 2, 7, 1'b0);
    tick_n(12);

    applyStimulus(1'b0, 1'b0, '0, 0, 0, 1'b1);
    tick_n(4);
    applyStimulus(1'b1, 1'b0, '0, 0, 0, 1'b1);
    tick_n(4);
    idle(3);

    reset_dut();
    load_cfg(24'd32768, 3, 0);
    tick_n(65540);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_dut();
      applyStimulus(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0),
                    PHASE_W'($urandom_range(0, 1 << 20)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, N-1)),
                    1'($urandom_range(0, 31) == 0));
    end

    idle(5);
    checkOutput("drain_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
